// File: rtl/pm_loader_pkg.sv
// Shared definitions for the picoMIPS program-memory loader: default sizes,
// FSM state codes and the opcode-legality check shared with the decoder.
`ifndef PM_OPCODE_LIST
`define PM_OPCODE_LIST 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B
`endif

package pm_loader_pkg;
    localparam int PSIZE = 6;
    localparam int ISIZE = 24;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    // 6'h3F is reserved and must never appear in the list.
    function automatic logic is_legal_opcode(input logic [5:0] op);
        return op inside {`PM_OPCODE_LIST};
    endfunction
endpackage

// File: rtl/pm_byte_packer.sv
// MSB-first byte-to-word packer; word_full_o flags the byte completing a word.
module pm_byte_packer
    import pm_loader_pkg::*;
#(
    parameter int Isize = ISIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [7:0]       byte_i,
    output logic [Isize-1:0] word_o,
    output logic             word_full_o
);
    localparam int B  = Isize / 8;
    localparam int CW = (B > 1) ? $clog2(B) : 1;

    logic [Isize-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign word_full_o = load_i && (cnt_q == CW'(B - 1));
    assign word_o      = sr_q;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sr_d  = (sr_q << 8) | Isize'(byte_i);
            cnt_d = word_full_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pm_loader.sv
// picoMIPS program-memory loader: count byte, N packed words, optional XOR
// checksum byte (enabled by defining PMLOAD_CHECKSUM_EN).
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter int Psize = PSIZE,
    parameter int Isize = ISIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             pm_we,
    output logic [Psize-1:0] pm_addr,
    output logic [Isize-1:0] pm_wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bad_op
);
    logic [2:0]       state_q, state_d;
    logic             rx_ready_q, rx_ready_d;
    logic [Psize-1:0] addr_q, addr_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             bad_op_q, bad_op_d;
    logic             acc, data_acc, word_full;
`ifdef PMLOAD_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    assign acc      = rx_valid && rx_ready_q;
    assign data_acc = acc && (state_q == S_DATA);

    pm_byte_packer #(.Isize(Isize)) u_packer (
        .clk         (clk),
        .reset       (reset),
        .load_i      (data_acc),
        .byte_i      (rx_data),
        .word_o      (pm_wdata),
        .word_full_o (word_full)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wcnt_d   = wcnt_q;
        bad_op_d = bad_op_q;
`ifdef PMLOAD_CHECKSUM_EN
        chk_d    = data_acc ? (chk_q ^ rx_data) : chk_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) begin
                state_d  = S_COUNT;
                bad_op_d = 1'b0;
            end
            S_COUNT: if (acc) begin
                if (rx_data == 8'd0 || 32'(rx_data) > (32'd1 << Psize)) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_DATA;
                    wcnt_d  = rx_data;
                    addr_d  = '0;
`ifdef PMLOAD_CHECKSUM_EN
                    chk_d   = 8'd0;
`endif
                end
            end
            S_DATA: if (word_full) state_d = S_WRITE;
            S_WRITE: begin
                addr_d = addr_q + 1'b1;
                wcnt_d = wcnt_q - 8'd1;
                if (!is_legal_opcode(pm_wdata[Isize-1:Isize-6])) bad_op_d = 1'b1;
`ifdef PMLOAD_CHECKSUM_EN
                state_d = (wcnt_q == 8'd1) ? S_CHECK : S_DATA;
`else
                state_d = (wcnt_q == 8'd1) ? S_DONE : S_DATA;
`endif
            end
`ifdef PMLOAD_CHECKSUM_EN
            S_CHECK: if (acc) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
        rx_ready_d = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            addr_q     <= '0;
            wcnt_q     <= '0;
            bad_op_q   <= 1'b0;
`ifdef PMLOAD_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            bad_op_q   <= bad_op_d;
`ifdef PMLOAD_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign rx_ready = rx_ready_q;
    assign pm_we    = (state_q == S_WRITE);
    assign pm_addr  = addr_q;
    assign busy     = (state_q == S_COUNT) || (state_q == S_DATA) ||
                      (state_q == S_WRITE) || (state_q == S_CHECK);
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign cpu_hold = (state_q != S_DONE);
    assign bad_op   = bad_op_q;
endmodule

// File: doc/pm_loader.md
# pm_loader

Program-memory loader for picoMIPS. It receives a byte stream over a valid/ready handshake and packs the bytes MSB-first into Isize-bit instruction words. It writes those words into program memory from address 0 upward and holds the CPU in reset-like stall until a load completes. It is the writer side of the instruction path that the instruction decoder reads.

## Interface
- Psize, 6, program-counter/program-memory address width
- Isize, 24, instruction width; must be a multiple of 8; B = Isize/8 bytes per word
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR; ignored while busy
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- pm_we  out  1  program-memory write strobe, exactly one cycle per word
- pm_addr  out  Psize  write address
- pm_wdata  out  Isize  instruction word
- cpu_hold  out  1  stalls the CPU (PCincr forced off externally) while high
- busy  out  1  load in progress
- done  out  1  level; last load succeeded
- err  out  1  level; last load failed
- bad_op  out  1  sticky; some loaded word had an opcode not in the opcode list

## Operation
- Reset values: rx_ready=0, pm_we=0, pm_addr=0, pm_wdata=0, cpu_hold=1, busy=0, done=0, err=0, bad_op=0. State is IDLE.
- A byte is accepted only on a cycle with rx_valid && rx_ready.
- States and transitions:
  - IDLE: on start, go to COUNT.
  - COUNT: accepts count byte N. N==0 or N>2^Psize goes to ERR. Otherwise go to DATA with the word counter at N and pm_addr at 0.
  - DATA: accepts B bytes. The first byte lands in pm_wdata[Isize-1:Isize-8]. After byte B, go to WRITE.
  - WRITE: rx_ready=0 and pm_we=1 for one cycle. Then increment pm_addr and decrement the word counter. If the counter is nonzero, go to DATA; otherwise go to CHECK (macro on) or DONE.
  - CHECK: accepts one checksum byte. A match goes to DONE; a mismatch goes to ERR.
  - DONE: done=1, cpu_hold=0.
  - ERR: err=1, cpu_hold=1.
- start from DONE or ERR clears done, err and bad_op, reasserts cpu_hold, and enters COUNT.
- busy=1 in COUNT, DATA, WRITE and CHECK.
- Opcode check: at WRITE, pm_wdata[Isize-1:Isize-6] is compared against the opcode list. An unlisted opcode sets bad_op. This is non-fatal: the word is still written. 6'h3F is reserved and never assigned.
- pm_addr wraps to 0 after 2^Psize-1. The wrap is never reached in legal use because N≤2^Psize.
- Reset asserted mid-load aborts immediately to reset values. Words already written remain in memory.

## Timing
- rx_ready is registered and is 1 exactly in COUNT, DATA and CHECK.
- start at cycle t gives rx_ready=1 at t+1.
- Throughput is B+1 cycles per word with back-to-back rx_valid.
- If the final data byte is accepted at cycle d, pm_we=1 at d+1.
- Without the macro, done=1 and cpu_hold=0 at d+2.
- With the macro, a checksum byte accepted at cycle c gives done/err at c+1.
- Count-byte error: err=1 one cycle after the count byte is accepted.
- rx_valid gaps stall the FSM in place. No byte is lost or duplicated.

## Configuration
- PMLOAD_CHECKSUM_EN defined: the CHECK state exists. The stream ends with one byte equal to the XOR of all data bytes; the count byte is excluded.
- PMLOAD_CHECKSUM_EN undefined: there is no CHECK state, and WRITE of the last word goes directly to DONE.

## Structure
- Shared package pm_loader_pkg holds the state enum, the Psize/Isize default constants, and the function is_legal_opcode(logic [5:0]). That function is built from the shared opcode macro list, so the decoder and loader stay consistent.
- One sub-module, pm_byte_packer, contains the MSB-first shift register, the byte counter 0..B-1, and the word_full flag.

## Test plan
Parameters Psize=6, Isize=24.
1. Reset asserted for 3 cycles -> all outputs hold the reset values listed above; cpu_hold=1.
2. Load with macro on: start, then 02, 00 11 22, 00 33 44, checksum 44 -> pm_we at addr 0 with 0x001122, then at addr 1 with 0x003344; done=1; cpu_hold=0; bad_op=0.
3. Same stream with checksum 45 -> err=1, done=0, cpu_hold=1. start then reloads the valid stream -> done=1.
4. Count byte 00, then separately count byte 41 -> err=1 the cycle after each count byte; pm_we is never asserted.
5. Word FC 00 00 (opcode 6'h3F), N=1 -> word is written, bad_op=1, done=1.
6. rx_valid toggled every other cycle during test 2, plus start pulsed mid-load -> identical writes; start is ignored. A separate run asserts reset mid-DATA -> outputs return to reset values immediately.
